// File: rtl/dsp_result_collector_if.sv
// Handshake bundle between the operand source, the DSP48A1 slice outputs, the downstream sink
// and the result collector. The master side is the environment; the slave side is the collector.
interface dsp_result_collector_if #(
    parameter int TAG_W = 4
);
    logic             flush;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_p;
    logic             res_carryout;
    logic [TAG_W-1:0] res_tag;
    logic [3:0]       in_flight;
    logic [4:0]       res_count;
    logic             issue_err;

    modport master (
        output flush, issue_valid, issue_tag, dsp_p, dsp_carryout, res_ready,
        input  issue_ready, res_valid, res_p, res_carryout, res_tag, in_flight, res_count, issue_err
    );

    modport slave (
        input  flush, issue_valid, issue_tag, dsp_p, dsp_carryout, res_ready,
        output issue_ready, res_valid, res_p, res_carryout, res_tag, in_flight, res_count, issue_err
    );
endinterface

// File: rtl/dsp_result_collector.sv
// Tracks operations through the DSP48A1 pipeline, captures P/CARRYOUT when they become valid,
// and buffers them in a credit-protected first-word-fall-through FIFO.
module dsp_result_collector #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    dsp_result_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [47:0]      p;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } result_t;

    logic [LATENCY-1:0] stage_vld;
    logic [TAG_W-1:0]   stage_tag [LATENCY];
    result_t            mem [FIFO_DEPTH];
    result_t            head;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      fill;
    logic [3:0]         in_flight_q;
    logic [4:0]         res_count;
    logic [4:0]         credits;
    logic               ready;
    logic               accept;
    logic               capture;
    logic               pop;
    logic               res_valid;
    logic               issue_err_q;

    // Occupancy comes from the pointer difference; the wrap bit separates full from empty.
    assign fill      = wr_ptr - rd_ptr;
    assign res_count = 5'(fill);
    assign credits   = 5'(in_flight_q) + res_count;

    // Credits use registered counts only, so a pop frees its slot from the next cycle on.
    assign ready     = rst_n && !bus.flush && (credits < 5'(FIFO_DEPTH));
    assign accept    = bus.issue_valid && ready;
    assign capture   = stage_vld[LATENCY-1];
    assign res_valid = (res_count != 5'd0);
    assign pop       = res_valid && bus.res_ready;

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
        end else if (bus.flush) begin
            stage_vld <= '0;
        end else begin
            stage_vld <= LATENCY'({stage_vld, accept});
        end
    end

    // NOTE: tag and buffer storage is not reset; only the valids and pointers qualify it.
    always_ff @(posedge clk) begin
        stage_tag[0] <= bus.issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            stage_tag[i] <= stage_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr[AW-1:0]] <= {bus.dsp_p, bus.dsp_carryout, stage_tag[LATENCY-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_flight_q <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_flight_q <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (accept && !capture) begin
                in_flight_q <= in_flight_q + 4'd1;
            end else if (capture && !accept) begin
                in_flight_q <= in_flight_q - 4'd1;
            end
        end
    end

    // Sticky protocol error; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_err_q <= 1'b0;
        end else if (bus.issue_valid && !ready) begin
            issue_err_q <= 1'b1;
        end
    end

    assign head             = mem[rd_ptr[AW-1:0]];
    assign bus.issue_ready  = ready;
    assign bus.res_valid    = res_valid;
    assign bus.res_p        = res_valid ? head.p     : 48'd0;
    assign bus.res_carryout = res_valid ? head.carry : 1'b0;
    assign bus.res_tag      = res_valid ? head.tag   : '0;
    assign bus.in_flight    = in_flight_q;
    assign bus.res_count    = res_count;
    assign bus.issue_err    = issue_err_q;
endmodule
